// File: rtl/anffl_tex_coorddenorm2d.sv
// Two-channel (U/V) texture coordinate denormalizer: signed fixed-point coordinate to
// power-of-two texel index with per-channel wrap/mirror/clamp, two-stage valid/ready pipeline.
module anffl_tex_coorddenorm2d #(
    parameter int COORD_W = 32,
    parameter int FRAC_W  = 16,
    parameter int EXP_W   = 4,
    parameter int MAX_EXP = 15,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_u,
    input  logic [COORD_W-1:0] in_v,
    input  logic [EXP_W-1:0]   in_exp_u,
    input  logic [EXP_W-1:0]   in_exp_v,
    input  logic [1:0]         in_mode_u,
    input  logic [1:0]         in_mode_v,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAX_EXP-1:0] out_idx_u,
    output logic [MAX_EXP-1:0] out_idx_v,
    output logic               out_oob_u,
    output logic               out_oob_v,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int S_W = COORD_W + MAX_EXP;
    localparam int T_W = S_W - FRAC_W;
    localparam logic [MAX_EXP:0] ONE_L = 1;

    logic               s1_valid_q;
    logic               s2_valid_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic [TAG_W-1:0]   s2_tag_q;
    logic               s1_adv;
    logic               s2_adv;

    logic [COORD_W-1:0] coord  [2];
    logic [EXP_W-1:0]   exp_in [2];
    logic [1:0]         mode_in[2];

    assign coord[0]   = in_u;
    assign coord[1]   = in_v;
    assign exp_in[0]  = in_exp_u;
    assign exp_in[1]  = in_exp_v;
    assign mode_in[0] = in_mode_u;
    assign mode_in[1] = in_mode_v;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [EXP_W-1:0]      e_d;
            logic [EXP_W-1:0]      e_q;
            logic signed [S_W-1:0] s_d;
            logic [T_W-1:0]        t_d;
            logic [T_W-1:0]        t_q;
            logic                  oob_d;
            logic                  oob_q;
            logic [1:0]            mode_q;
            logic [MAX_EXP:0]      len_d;
            logic [MAX_EXP-1:0]    mask_d;
            logic [MAX_EXP-1:0]    t_lo_d;
            logic [MAX_EXP-1:0]    idx_d;
            logic [MAX_EXP-1:0]    idx_q;
            logic                  oob_out_q;

            // Sign-extend by MAX_EXP bits first so the scale-up by 2^e can never overflow.
            assign e_d   = (exp_in[gi] > EXP_W'(MAX_EXP)) ? EXP_W'(MAX_EXP) : exp_in[gi];
            assign s_d   = $signed({{MAX_EXP{coord[gi][COORD_W-1]}}, coord[gi]}) <<< e_d;
            assign t_d   = T_W'(s_d >>> FRAC_W);
            assign oob_d = t_d[T_W-1] | (|(t_d >> e_d));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    e_q    <= '0;
                    mode_q <= '0;
                    t_q    <= '0;
                    oob_q  <= 1'b0;
                end else if (s1_adv && in_valid) begin
                    e_q    <= e_d;
                    mode_q <= mode_in[gi];
                    t_q    <= t_d;
                    oob_q  <= oob_d;
                end
            end

            assign len_d  = ONE_L << e_q;
            assign mask_d = MAX_EXP'(len_d - ONE_L);
            assign t_lo_d = t_q[MAX_EXP-1:0];

            // Mirror: when bit e of t is set we are in the reflected half, and 2L-1-p
            // reduces to the bitwise complement of the low e bits.
            always_comb begin
                idx_d = t_lo_d & mask_d;
                case (mode_q)
                    2'b01: begin
                        if (t_q[e_q]) begin
                            idx_d = ~t_lo_d & mask_d;
                        end
                    end
                    2'b10: begin
                        if (t_q[T_W-1]) begin
                            idx_d = '0;
                        end else if (oob_q) begin
                            idx_d = mask_d;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    idx_q     <= '0;
                    oob_out_q <= 1'b0;
                end else if (s2_adv && s1_valid_q) begin
                    idx_q     <= idx_d;
                    oob_out_q <= oob_q;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_tag_q <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_tag   = s2_tag_q;
    assign out_idx_u = g_ch[0].idx_q;
    assign out_idx_v = g_ch[1].idx_q;
    assign out_oob_u = g_ch[0].oob_out_q;
    assign out_oob_v = g_ch[1].oob_out_q;

endmodule

// File: tb/tb_anffl_tex_coorddenorm2d.sv
// Bench for anffl_tex_coorddenorm2d: directed cases with hand-derived results, then
// randomized traffic checked against an integer-arithmetic reference model.
module tb_anffl_tex_coorddenorm2d;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_u, in_v;
    logic [3:0]  in_exp_u, in_exp_v;
    logic [1:0]  in_mode_u, in_mode_v;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_idx_u, out_idx_v;
    logic        out_oob_u, out_oob_v;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    anffl_tex_coorddenorm2d dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_u(in_u), .in_v(in_v),
        .in_exp_u(in_exp_u), .in_exp_v(in_exp_v),
        .in_mode_u(in_mode_u), .in_mode_v(in_mode_v),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx_u(out_idx_u), .out_idx_v(out_idx_v),
        .out_oob_u(out_oob_u), .out_oob_v(out_oob_v),
        .out_tag(out_tag)
    );

    typedef struct {
        logic [14:0] iu, iv;
        logic        ou, ov;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] u, v;
        logic [3:0]  eu, ev;
        logic [1:0]  mu, mv;
        logic [3:0]  tag;
        logic [14:0] iu, iv;
        logic        ou, ov;
    } dir_t;

    exp_t        q[$];
    exp_t        dir_exp;
    bit          dir_mode;
    bit          lat_chk;
    bit          stall_prev;
    logic [35:0] held;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          accepts = 0;
    int          pops = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Reference: real-number semantics via 64-bit integers (value * 2^e, floored).
    function automatic void ref_chan(input logic [31:0] c, input logic [3:0] ex, input logic [1:0] m,
                                     output logic [14:0] idx, output logic oob);
        int     e;
        longint len, t, r, p;
        e   = (ex > 4'd15) ? 15 : int'(ex);
        len = longint'(1) << e;
        t   = (longint'($signed(c)) * len) >>> 16;
        oob = (t < 0) || (t >= len);
        case (m)
            2'b10:   r = (t < 0) ? 0 : ((t >= len) ? len - 1 : t);
            2'b01: begin
                p = ((t % (2 * len)) + 2 * len) % (2 * len);
                r = (p < len) ? p : 2 * len - 1 - p;
            end
            default: r = ((t % len) + len) % len;
        endcase
        idx = 15'(r);
    endfunction

    function automatic exp_t model();
        exp_t e;
        ref_chan(in_u, in_exp_u, in_mode_u, e.iu, e.ou);
        ref_chan(in_v, in_exp_v, in_mode_v, e.iv, e.ov);
        e.tag = in_tag;
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_coord();
        if ($urandom_range(0, 2) == 0) return $urandom;
        return 32'(int'($urandom_range(0, 262143)) - 131072);
    endfunction

    task automatic rand_inputs();
        in_u      = rand_coord();
        in_v      = rand_coord();
        in_exp_u  = 4'($urandom_range(0, 15));
        in_exp_v  = 4'($urandom_range(0, 15));
        in_mode_u = 2'($urandom_range(0, 3));
        in_mode_v = 2'($urandom_range(0, 3));
        in_tag    = 4'($urandom_range(0, 15));
    endtask

    // One clock cycle: sample just after the falling edge, then advance to the next one.
    task automatic cycle();
        exp_t e;
        #1;
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_hold", {out_idx_u, out_idx_v, out_oob_u, out_oob_v, out_tag}, held);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("idx_u", out_idx_u, e.iu);
                chk("idx_v", out_idx_v, e.iv);
                chk("oob_u", out_oob_u, e.ou);
                chk("oob_v", out_oob_v, e.ov);
                chk("tag", out_tag, e.tag);
                if (lat_chk) chk("latency", cyc - e.acc, 2);
                pops++;
                $display("t=%0t out idx_u=%0d idx_v=%0d oob=%b%b tag=%0h", $time,
                         out_idx_u, out_idx_v, out_oob_u, out_oob_v, out_tag);
            end
        end
        if (in_valid && in_ready) begin
            e     = dir_mode ? dir_exp : model();
            e.acc = cyc;
            q.push_back(e);
            accepts++;
        end
        stall_prev = out_valid && !out_ready;
        held       = {out_idx_u, out_idx_v, out_oob_u, out_oob_v, out_tag};
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    dir_t dir_tab[14];

    initial begin
        dir_tab[0]  = '{32'h00008000, 32'h0, 4, 0, 2'b00, 2'b00, 4'h1, 15'd8,  15'd0,  1'b0, 1'b0};
        dir_tab[1]  = '{32'h00008000, 32'h0, 4, 0, 2'b01, 2'b00, 4'h2, 15'd8,  15'd0,  1'b0, 1'b0};
        dir_tab[2]  = '{32'h00008000, 32'h0, 4, 0, 2'b10, 2'b00, 4'h3, 15'd8,  15'd0,  1'b0, 1'b0};
        dir_tab[3]  = '{32'h00008000, 32'h0, 4, 0, 2'b11, 2'b00, 4'h4, 15'd8,  15'd0,  1'b0, 1'b0};
        dir_tab[4]  = '{32'hFFFFC000, 32'h0, 4, 0, 2'b00, 2'b00, 4'h5, 15'd12, 15'd0,  1'b1, 1'b0};
        dir_tab[5]  = '{32'hFFFFC000, 32'h0, 4, 0, 2'b10, 2'b00, 4'h6, 15'd0,  15'd0,  1'b1, 1'b0};
        dir_tab[6]  = '{32'hFFFFC000, 32'h0, 4, 0, 2'b01, 2'b00, 4'h7, 15'd3,  15'd0,  1'b1, 1'b0};
        dir_tab[7]  = '{32'h0, 32'h00018000, 0, 4, 2'b00, 2'b00, 4'h8, 15'd0,  15'd8,  1'b0, 1'b1};
        dir_tab[8]  = '{32'h0, 32'h00018000, 0, 4, 2'b00, 2'b10, 4'h9, 15'd0,  15'd15, 1'b0, 1'b1};
        dir_tab[9]  = '{32'h0, 32'h00018000, 0, 4, 2'b00, 2'b01, 4'hB, 15'd0,  15'd7,  1'b0, 1'b1};
        dir_tab[10] = '{32'h0, 32'h00018000, 0, 0, 2'b00, 2'b00, 4'hC, 15'd0,  15'd0,  1'b0, 1'b1};
        dir_tab[11] = '{32'h0, 32'h00018000, 0, 0, 2'b00, 2'b10, 4'hD, 15'd0,  15'd0,  1'b0, 1'b1};
        dir_tab[12] = '{32'h0, 32'h00018000, 0, 0, 2'b00, 2'b01, 4'hE, 15'd0,  15'd0,  1'b0, 1'b1};
        dir_tab[13] = '{32'h0000E000, 32'h00012000, 3, 5, 2'b00, 2'b01, 4'hA, 15'd7, 15'd27, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_u = '0; in_v = '0; in_exp_u = '0; in_exp_v = '0;
        in_mode_u = '0; in_mode_v = '0; in_tag = '0;
        dir_mode = 1'b0; lat_chk = 1'b0; stall_prev = 1'b0;

        // Reset state.
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_data", {out_idx_u, out_idx_v, out_oob_u, out_oob_v, out_tag}, 36'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed, back to back with no backpressure: values and 2-cycle latency.
        dir_mode = 1'b1;
        lat_chk  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid  = 1'b1;
            in_u = dir_tab[i].u;  in_v = dir_tab[i].v;
            in_exp_u = dir_tab[i].eu;  in_exp_v = dir_tab[i].ev;
            in_mode_u = dir_tab[i].mu; in_mode_v = dir_tab[i].mv;
            in_tag = dir_tab[i].tag;
            dir_exp = '{dir_tab[i].iu, dir_tab[i].iv, dir_tab[i].ou, dir_tab[i].ov, dir_tab[i].tag, 0};
            cycle();
        end
        in_valid = 1'b0;
        dir_mode = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("directed_drained", q.size(), 0);

        // Backpressure: 4 offers with out_ready low, only 2 fit.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        accepts   = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            rand_inputs();
            cycle();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_accepts", accepts, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        @(negedge clk);
        cyc++;
        out_ready = 1'b1;
        pops = 0;
        cycle();
        cycle();
        chk("bp_pops", pops, 2);
        chk("bp_drained", q.size(), 0);

        // Asynchronous reset with two entries in flight.
        lat_chk = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            rand_inputs();
            cycle();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_data", {out_idx_u, out_oob_u, out_tag}, 20'h0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        cycle();
        in_valid = 1'b0;
        pops = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("post_rst_pops", pops, 1);

        // Random traffic with random backpressure.
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_inputs();
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("random_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/anffl_tex_coorddenorm2d.md
Name: anfFl_tex_coordDenorm2d

Overview:
Pipelined two-channel (U/V) texture coordinate denormalizer. It converts signed fixed-point texture coordinates into integer texel indices for power-of-two texture dimensions. Each channel selects its own addressing mode: wrap, mirror or clamp. The block sits between the texture coordinate interpolator and the texel address generator. Both sides use valid/ready handshakes, and a tag is carried through untouched.

Parameters:
COORD_W, 32, total width of each signed fixed-point coordinate input
FRAC_W, 16, number of fractional bits in each coordinate (FRAC_W < COORD_W)
EXP_W, 4, width of each log2-dimension input
MAX_EXP, 15, largest supported log2 dimension; also the output index width (MAX_EXP <= 2**EXP_W - 1)
TAG_W, 4, width of the sideband tag passed through unchanged

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input request valid
in_ready  out  1  block can accept an input this cycle
in_u, in_v  in  COORD_W  signed fixed-point coordinates
in_exp_u, in_exp_v  in  EXP_W  log2 of texture width and height
in_mode_u, in_mode_v  in  2  addressing mode: 00 wrap, 01 mirror, 10 clamp, 11 treated as wrap
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_idx_u, out_idx_v  out  MAX_EXP  texel indices
out_oob_u, out_oob_v  out  1  coordinate fell outside [0,1) before mode handling
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset is asynchronous and active-high; rst is in the sensitivity list of every register.
- While rst is asserted: both stage-valid bits are 0, out_valid = 0, all out_* data = 0, in_ready = 0.
- Per channel, with e = min(in_exp, MAX_EXP) and L = 2^e:
  - s = sign-extended coordinate arithmetically shifted left by e; intermediate width COORD_W+MAX_EXP, no overflow possible.
  - t = s arithmetically shifted right by FRAC_W, i.e. floor toward minus infinity.
  - oob = (t < 0) or (t >= L).
- Mode results:
  - WRAP: idx = t mod L, i.e. the low e bits of t.
  - CLAMP: idx = 0 if t < 0; L-1 if t >= L; t otherwise.
  - MIRROR: p = t mod 2L (low e+1 bits); idx = p if p < L, else 2L-1-p.
  - Output bits at and above position e are always 0. For e = 0, idx = 0 in every mode.
- Pipeline has two register stages:
  - S1 registers e, mode, t, oob and tag for both channels.
  - S2 applies the mode and drives the out_* registers directly.
- Latency is 2 cycles from an accepted input to out_valid when there is no backpressure. Throughput is 1 result per cycle.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances (and not in reset).
- While out_valid = 1 and out_ready = 0, all out_* signals hold stable.
- Simultaneous accept and drain in the same cycle keeps full throughput with no bubble.
- Ordering is strictly FIFO; no result is dropped or duplicated.
- Reset asserted mid-stream discards all in-flight entries. The first input accepted after reset release appears 2 cycles later.
- Mode 11 behaves exactly like mode 00.

Test Plan:
- Basic, FRAC_W=16: u=0x00008000 (0.5), exp_u=4, all three modes -> idx_u=8, oob_u=0, out_valid exactly 2 cycles after acceptance.
- Negative coordinate: u=0xFFFFC000 (-0.25), exp_u=4 -> wrap 12, clamp 0, mirror 3; oob_u=1 in every mode.
- Above range: v=0x00018000 (1.5), exp_v=4 -> wrap 8, clamp 15, mirror 7, oob_v=1. Same v with exp_v=0 -> idx 0 in all modes.
- Independent channels and tag: u wrap exp 3 coord 0x0000E000, v mirror exp 5 coord 0x00012000, tag=0xA -> idx_u=7, idx_v=27, out_tag=0xA.
- Backpressure:
  - Hold out_ready=0 and offer 4 back-to-back inputs -> exactly 2 accepted, then in_ready=0, with outputs stable.
  - Raise out_ready -> all results emerge in order, one per cycle, with no loss.
- Reset mid-operation: assert rst with 2 entries in flight -> out_valid=0 immediately (asynchronously), in-flight entries discarded. After release, a new input emerges after 2 cycles with correct values.
